// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// One shared shift/add-subtract datapath; one result bit per RUN cycle, sign fix-up in FIX.
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc_hi, acc_lo, bm, a_orig;
  logic           sa, sb, is_div, b_zero;

  logic           sgn_op;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     add_sum;
  logic [W:0]     shifted;
  logic [W+1:0]   trial;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   q_fix, r_fix;

  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !op[2]) state_n = RUN;
      RUN:     if (cnt == CW'(W - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_comb begin
    sgn_op   = ~op[0];
    a_mag    = (sgn_op && a[W-1]) ? -a : a;
    b_mag    = (sgn_op && b[W-1]) ? -b : b;
    add_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? bm : {W{1'b0}})};
    // Partial remainder shifted left can reach 2*bm-1, so the trial needs two extra bits.
    shifted  = {acc_hi, acc_lo[W-1]};
    trial    = {1'b0, shifted} - {2'b00, bm};
    prod_fix = (sa ^ sb) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    q_fix    = (sa ^ sb) ? -acc_lo : acc_lo;
    r_fix    = sa ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      bm     <= '0;
      a_orig <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      is_div <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            if (!op[2]) begin
              // Multiply keeps the multiplier in acc_lo; divide keeps the dividend there.
              acc_hi <= '0;
              acc_lo <= op[1] ? a_mag : b_mag;
              bm     <= op[1] ? b_mag : a_mag;
              sa     <= sgn_op & a[W-1];
              sb     <= sgn_op & b[W-1];
              is_div <= op[1];
              b_zero <= (b == '0);
              a_orig <= a;
              cnt    <= '0;
            end else if (op == 3'd4) begin
              hi <= a;
            end else if (op == 3'd5) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            if (!trial[W+1]) begin
              acc_hi <= trial[W-1:0];
              acc_lo <= {acc_lo[W-2:0], 1'b1};
            end else begin
              acc_hi <= shifted[W-1:0];
              acc_lo <= {acc_lo[W-2:0], 1'b0};
            end
          end else begin
            {acc_hi, acc_lo} <= {add_sum, acc_lo[W-1:1]};
          end
        end
        FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (b_zero) begin
              hi <= a_orig;
              lo <= '1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
